// File: rtl/demux2_pkg.sv
// Shared types for the registered 1:2 stream demultiplexer.
package demux2_pkg;
    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_t;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;
endpackage

// File: rtl/demux_slot.sv
// One output slot: EMPTY/FULL state machine, holding register and delivered-word counter.
module demux_slot
    import demux2_pkg::*;
#(
    parameter int N  = 1,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [N-1:0]  din,
    output logic          valid,
    input  logic          ready,
    output logic [N-1:0]  dout,
    output logic [CW-1:0] cnt
);
    slot_state_t state, state_nx;
    logic        out_x;

    assign out_x = valid & ready;

    // A load wins over a drain, so a refill in the same cycle as a delivery keeps the slot full.
    always_comb begin
        state_nx = state;
        if (load)
            state_nx = SLOT_FULL;
        else if (out_x)
            state_nx = SLOT_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SLOT_EMPTY;
            valid <= 1'b0;
            dout  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            valid <= (state_nx == SLOT_FULL);
            if (load)
                dout <= din;
            if (out_x)
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/demux2_pipe.sv
// Registered 1:2 demux: s-decode and ready_in logic in front of two independent output slots.
module demux2_pipe
    import demux2_pkg::*;
#(
    parameter int N  = 1,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  d,
    input  logic          s,
    input  logic          valid_in,
    output logic          ready_in,
    output logic [N-1:0]  y0,
    output logic          valid0,
    input  logic          ready0,
    output logic [N-1:0]  y1,
    output logic          valid1,
    input  logic          ready1,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);
    logic [1:0]         rdy, vld, sel, load;
    logic [1:0][N-1:0]  dat;
    logic [1:0][CW-1:0] cn;

    assign rdy = {ready1, ready0};
    assign sel = {s == SEL_OUT1, s == SEL_OUT0};

    // Only the selected slot gates acceptance; the other slot's state never matters.
    assign ready_in = ~vld[s] | rdy[s];
    assign load     = {2{valid_in & ready_in}} & sel;

    for (genvar k = 0; k < 2; k++) begin : g_slot
        demux_slot #(.N(N), .CW(CW)) u_slot (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (load[k]),
            .din     (d),
            .valid   (vld[k]),
            .ready   (rdy[k]),
            .dout    (dat[k]),
            .cnt     (cn[k])
        );
    end

    assign y0     = dat[0];
    assign y1     = dat[1];
    assign valid0 = vld[0];
    assign valid1 = vld[1];
    assign cnt0   = cn[0];
    assign cnt1   = cn[1];
endmodule

// File: tb/tb_demux2_pipe.sv
// Self-checking bench for demux2_pipe (N=8, CW=4): per-output scoreboard queues plus vector table.
module tb_demux2_pipe;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] d = '0;
    logic       s = 1'b0;
    logic       valid_in = 1'b0;
    logic       ready_in;
    logic [7:0] y0, y1;
    logic       valid0, valid1;
    logic       ready0 = 1'b0, ready1 = 1'b0;
    logic [3:0] cnt0, cnt1;

    demux2_pipe #(.N(8), .CW(4)) dut (
        .clk(clk), .reset_n(reset_n), .d(d), .s(s), .valid_in(valid_in), .ready_in(ready_in),
        .y0(y0), .valid0(valid0), .ready0(ready0),
        .y1(y1), .valid1(valid1), .ready1(ready1),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: each queue holds the word the slot must be presenting (at most one).
    logic [7:0] q0[$], q1[$];
    logic [3:0] mcnt0 = '0, mcnt1 = '0;
    logic       yz0 = 1'b0, yz1 = 1'b0, known = 1'b0;

    // Values sampled mid-cycle by the last step, for the hand-written checks.
    logic       c_rdy, c_v0, c_v1;
    logic [7:0] c_y0, c_y1;
    logic [3:0] c_c0, c_c1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check against the scoreboard, then
    // advance the scoreboard by what the rising edge will do.
    task automatic step(input logic rst, input logic v, input logic [7:0] dd, input logic ss,
                        input logic r0, input logic r1);
        logic er, in_x, o0, o1;
        @(negedge clk);
        reset_n = ~rst; valid_in = v; d = dd; s = ss; ready0 = r0; ready1 = r1;
        #1;
        c_rdy = ready_in; c_v0 = valid0; c_v1 = valid1;
        c_y0 = y0; c_y1 = y1; c_c0 = cnt0; c_c1 = cnt1;
        er = ss ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
        if (known) begin
            chk("ready_in", {31'd0, ready_in}, {31'd0, er});
            chk("valid0", {31'd0, valid0}, {31'd0, q0.size() != 0});
            chk("valid1", {31'd0, valid1}, {31'd0, q1.size() != 0});
            if (q0.size() != 0) chk("y0", {24'd0, y0}, {24'd0, q0[0]});
            else if (yz0)       chk("y0_reset", {24'd0, y0}, 32'd0);
            if (q1.size() != 0) chk("y1", {24'd0, y1}, {24'd0, q1[0]});
            else if (yz1)       chk("y1_reset", {24'd0, y1}, 32'd0);
            chk("cnt0", {28'd0, cnt0}, {28'd0, mcnt0});
            chk("cnt1", {28'd0, cnt1}, {28'd0, mcnt1});
        end
        if (rst) begin
            q0.delete(); q1.delete();
            mcnt0 = '0; mcnt1 = '0;
            yz0 = 1'b1; yz1 = 1'b1; known = 1'b1;
        end else begin
            in_x = v & er;
            o0 = (q0.size() != 0) && r0;
            o1 = (q1.size() != 0) && r1;
            if (o0) begin void'(q0.pop_front()); mcnt0++; end
            if (o1) begin void'(q1.pop_front()); mcnt1++; end
            if (in_x) begin
                if (ss) begin q1.push_back(dd); yz1 = 1'b0; end
                else    begin q0.push_back(dd); yz0 = 1'b0; end
            end
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       s;
        logic       rdy, v0, v1;
        logic [7:0] y0, y1;
        logic [3:0] c0, c1;
    } vec_t;

    vec_t tbl[4];

    initial begin
        // 1. Reset held two cycles with a live input that must be ignored.
        step(1, 1, 8'hAA, 1, 1, 1);
        step(1, 1, 8'hAA, 1, 1, 1);
        chk("rst_valid1", {31'd0, c_v1}, 32'd0);
        chk("rst_y1", {24'd0, c_y1}, 32'd0);
        chk("rst_cnt0", {28'd0, c_c0}, 32'd0);

        // 2. Routing, table driven; expected values are those seen before each edge.
        tbl[0] = '{1, 8'h11, 0, 1, 0, 0, 8'h00, 8'h00, 4'd0, 4'd0};
        tbl[1] = '{1, 8'h22, 1, 1, 1, 0, 8'h11, 8'h00, 4'd0, 4'd0};
        tbl[2] = '{0, 8'h00, 0, 1, 0, 1, 8'h11, 8'h22, 4'd1, 4'd0};
        tbl[3] = '{0, 8'h00, 0, 1, 0, 0, 8'h11, 8'h22, 4'd1, 4'd1};
        for (int i = 0; i < 4; i++) begin
            step(0, tbl[i].v, tbl[i].d, tbl[i].s, 1, 1);
            chk($sformatf("tbl%0d_rdy", i), {31'd0, c_rdy}, {31'd0, tbl[i].rdy});
            chk($sformatf("tbl%0d_v0", i), {31'd0, c_v0}, {31'd0, tbl[i].v0});
            chk($sformatf("tbl%0d_v1", i), {31'd0, c_v1}, {31'd0, tbl[i].v1});
            chk($sformatf("tbl%0d_y0", i), {24'd0, c_y0}, {24'd0, tbl[i].y0});
            chk($sformatf("tbl%0d_y1", i), {24'd0, c_y1}, {24'd0, tbl[i].y1});
            chk($sformatf("tbl%0d_c0", i), {28'd0, c_c0}, {28'd0, tbl[i].c0});
            chk($sformatf("tbl%0d_c1", i), {28'd0, c_c1}, {28'd0, tbl[i].c1});
        end

        // 3. Output 0 stalled; output 1 traffic must still flow.
        step(0, 1, 8'h33, 0, 0, 1);
        step(0, 1, 8'h44, 0, 0, 1);
        chk("stall_rdy0", {31'd0, c_rdy}, 32'd0);
        chk("stall_y0", {24'd0, c_y0}, 32'h33);
        step(0, 1, 8'h55, 1, 0, 1);
        chk("bypass_rdy1", {31'd0, c_rdy}, 32'd1);
        step(0, 0, 8'h00, 0, 0, 1);
        chk("bypass_y1", {24'd0, c_y1}, 32'h55);
        chk("stall_hold_y0", {24'd0, c_y0}, 32'h33);
        step(0, 1, 8'h44, 0, 1, 1);
        chk("release_y0_a", {24'd0, c_y0}, 32'h33);
        step(0, 0, 8'h00, 0, 1, 1);
        chk("release_y0_b", {24'd0, c_y0}, 32'h44);
        chk("release_v0_b", {31'd0, c_v0}, 32'd1);

        // 4. Sixteen back-to-back words on output 1 from a fresh counter.
        step(1, 0, 8'h00, 0, 1, 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 8'(8'hC0 + i), 1, 0, 1);
            chk("stream_rdy", {31'd0, c_rdy}, 32'd1);
            if (i > 0) chk("stream_v1", {31'd0, c_v1}, 32'd1);
        end
        step(0, 0, 8'h00, 0, 0, 1);
        chk("stream_last_y1", {24'd0, c_y1}, 32'hCF);
        chk("stream_cnt1_15", {28'd0, c_c1}, 32'd15);
        step(0, 0, 8'h00, 0, 0, 1);
        chk("stream_cnt1_wrap", {28'd0, c_c1}, 32'd0);

        // 5. Delivery and refill of slot 1 in the same cycle.
        step(0, 1, 8'h66, 1, 0, 0);
        step(0, 1, 8'h77, 1, 0, 1);
        chk("simul_rdy", {31'd0, c_rdy}, 32'd1);
        chk("simul_y1_a", {24'd0, c_y1}, 32'h66);
        step(0, 0, 8'h00, 0, 0, 0);
        chk("simul_v1", {31'd0, c_v1}, 32'd1);
        chk("simul_y1_b", {24'd0, c_y1}, 32'h77);
        chk("simul_cnt1", {28'd0, c_c1}, 32'd1);

        // 6. Reset pulse with both slots full and stalled.
        step(0, 1, 8'h88, 0, 0, 0);
        step(0, 1, 8'h99, 1, 0, 0);
        step(1, 1, 8'hAA, 0, 0, 0);
        chk("pre_rst_v0", {31'd0, c_v0}, 32'd1);
        step(0, 0, 8'h00, 0, 0, 0);
        chk("post_rst_v0", {31'd0, c_v0}, 32'd0);
        chk("post_rst_v1", {31'd0, c_v1}, 32'd0);
        chk("post_rst_y0", {24'd0, c_y0}, 32'd0);
        chk("post_rst_cnt1", {28'd0, c_c1}, 32'd0);
        step(0, 1, 8'h12, 0, 1, 1);
        step(0, 0, 8'h00, 0, 1, 1);
        chk("resume_y0", {24'd0, c_y0}, 32'h12);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++)
            step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(0, 0, 8'h00, 0, 1, 1);
        step(0, 0, 8'h00, 0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/demux2_pipe.md
Name: demux2_pipe

Overview:
- Registered 1:2, N-bit stream demultiplexer: the splitting counterpart of the toolbox 2:1 mux.
- One input stream is steered by a 1-bit selector to one of two output streams, with valid/ready handshakes on every side.
- Each output has a one-entry holding register, so a stalled output never blocks traffic headed to the other output.
- Each output also keeps a wrapping delivered-word counter for debug and test.

Parameters:
- N, 1: data width of the input and of both outputs.
- CW, 8: width of each delivered-word counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- d  input  N  input data word.
- s  input  1  destination select: 0 → output 0, 1 → output 1.
- valid_in  input  1  d/s are valid this cycle.
- ready_in  output  1  the block accepts d/s this cycle.
- y0  output  N  output 0 data.
- valid0  output  1  y0 is valid.
- ready0  input  1  output 0 consumer accepts.
- y1  output  N  output 1 data.
- valid1  output  1  y1 is valid.
- ready1  input  1  output 1 consumer accepts.
- cnt0  output  CW  number of words delivered on output 0, modulo 2^CW.
- cnt1  output  CW  number of words delivered on output 1, modulo 2^CW.

Behaviour:
- Interface: one clock, clk; reset_n is synchronous and active-low.
- Reset (reset_n=0 at a clk edge):
  - valid0=valid1=0; y0=y1=0; cnt0=cnt1=0; both slots go to EMPTY.
  - Reset wins over every other event in that cycle; any held data is discarded.
- Transfer definitions:
  - Input transfer: valid_in & ready_in at a clk edge.
  - Output k transfer: validk & readyk at a clk edge.
- Per-slot state machine (slot k), states EMPTY and FULL:
  - EMPTY → FULL: input transfer with s==k; yk <= d.
  - FULL → EMPTY: output k transfer with no input transfer to k in the same cycle.
  - FULL → FULL: simultaneous output k transfer and input transfer with s==k; yk <= d (pass-through refill, no bubble).
  - FULL → FULL: no output k transfer; yk held stable.
  - validk = (state==FULL), driven from a register.
- Ready rule:
  - ready_in = (state[s]==EMPTY) | ready[s].
  - ready_in is combinational from s, ready0/ready1 and slot state. It never depends on valid_in.
  - An input headed to a stalled, full slot is refused even if the other slot is empty. There is no reordering or bypass.
- Latency: one cycle from input transfer to validk=1. Throughput: one word per cycle when the consumer keeps readyk=1.
- Output stability: while validk=1 and readyk=0, yk and validk must not change.
- Counters: cntk increments by 1 on each output k transfer and wraps from 2^CW-1 to 0 with no flag. The two counters are independent and may increment in the same cycle.
- Ordering: words to the same output leave in acceptance order. No ordering is implied between outputs.
- Don't-care inputs: when valid_in=0, d and s are ignored for state updates. ready_in still reflects the current s.
- Reset mid-operation: a full slot is emptied and its word lost. Consumers must not see validk=1 in the cycle after reset is asserted.

Decomposition:
- Package demux2_pkg holds:
  - typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
  - localparams SEL_OUT0=1'b0, SEL_OUT1=1'b1.
- Sub-module demux_slot #(N, CW):
  - Ports: clk, reset_n, load, din, valid, ready, dout, cnt.
  - Contents: one slot state machine, its data register and its delivered counter.
  - Instantiated twice. The top level holds only the s-decode and the ready_in logic.

Test Plan (N=8, CW=4):
1. Reset: hold reset_n=0 for 2 cycles with valid_in=1, d=8'hAA, s=1. Required: valid0=valid1=0, y0=y1=0, cnt0=cnt1=0, and no word accepted into either slot.
2. Routing: send d=8'h11 s=0, then d=8'h22 s=1, with ready0=ready1=1. Required: y0=8'h11 valid0=1 in the cycle after the first transfer; y1=8'h22 valid1=1 one cycle later; cnt0=1, cnt1=1.
3. Independent stall:
   - Setup: ready0=0; send 8'h33 s=0, then 8'h44 s=0, then 8'h55 s=1.
   - Required: 8'h33 is held in y0; ready_in=0 while s=0; 8'h55 is still accepted and delivered on y1.
   - Release ready0=1: y0 shows 8'h33, then 8'h44, in that order.
4. Back-to-back streaming: 16 consecutive words with s=1, ready1=1. Required: one word per cycle with no bubbles; cnt1 wraps to 0 after the 16th delivery.
5. Simultaneous events: with slot 1 FULL (y1=8'h66) and ready1=1, input 8'h77 s=1 in the same cycle. Required: valid1 stays 1, y1=8'h77 next cycle, cnt1 increments once.
6. Mid-operation reset: both slots full and stalled, then pulse reset_n=0 for 1 cycle. Required: valid0=valid1=0, y0=y1=0 and cnt0=cnt1=0 after that edge; normal operation resumes on the next input transfer.
